// File: rtl/alu_execute.sv
// Registered ALU execute stage with valid/ready handshakes on both sides.
// Define ALU_MULDIV_EN to build the iterative MUL/DIV/MOD engine (codes 10-12).
module alu_execute #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             div_zero
);
  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_ADC   = 5'd2;
  localparam logic [4:0] OP_SBB   = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_NOT   = 5'd7;
  localparam logic [4:0] OP_SHL   = 5'd8;
  localparam logic [4:0] OP_SHR   = 5'd9;
  localparam logic [4:0] OP_MUL   = 5'd10;
  localparam logic [4:0] OP_DIV   = 5'd11;
  localparam logic [4:0] OP_MOD   = 5'd12;
  localparam logic [4:0] OP_IMMED = 5'd13;
  localparam logic [4:0] WIDTH_5  = 5'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
    S_CALC = 2'd1,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             div_zero_q, div_zero_d;

  logic             accept;
  logic             is_iter;
  logic             cin;
  logic [4:0]       shamt;
  logic [WIDTH:0]   add_sum, sub_diff, shl_full, shr_full;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry;

`ifdef ALU_MULDIV_EN
  logic [4:0]       step_q, step_d;
  logic [4:0]       kind_q, kind_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] fin_result;

  assign is_iter    = (operation == OP_MUL) || (operation == OP_DIV) || (operation == OP_MOD);
  assign rem_shift  = {acc_q, work_q[WIDTH-1]};
  assign rem_sub    = rem_shift[WIDTH-1:0] - opnd_q;
  // With a zero divisor the restoring loop naturally yields all-ones quotient and remainder == op_a.
  assign fin_result = (kind_q == OP_DIV) ? work_q : acc_q;
`else
  assign is_iter = 1'b0;
`endif

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign cin       = ((operation == OP_ADC) || (operation == OP_SBB)) ? carry_q : 1'b0;
  assign shamt     = op_b[4:0];
  assign add_sum   = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
  assign sub_diff  = {1'b0, op_a} - {1'b0, op_b} - {{WIDTH{1'b0}}, cin};
  assign shl_full  = {1'b0, op_a} << shamt;
  assign shr_full  = {op_a, 1'b0} >> shamt;

  // Result and carry for every operation that completes in its accept cycle.
  always_comb begin
    sc_result = {WIDTH{1'b0}};
    sc_carry  = carry_q;
    case (operation)
      OP_ADD, OP_ADC: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_carry  = add_sum[WIDTH];
      end
      OP_SUB, OP_SBB: begin
        sc_result = sub_diff[WIDTH-1:0];
        sc_carry  = sub_diff[WIDTH];
      end
      OP_AND:   sc_result = op_a & op_b;
      OP_OR:    sc_result = op_a | op_b;
      OP_XOR:   sc_result = op_a ^ op_b;
      OP_NOT:   sc_result = ~op_a;
      OP_SHL: begin
        if (shamt >= WIDTH_5) begin
          sc_carry = 1'b0;
        end else begin
          sc_result = shl_full[WIDTH-1:0];
          sc_carry  = shl_full[WIDTH];
        end
      end
      OP_SHR: begin
        if (shamt >= WIDTH_5) begin
          sc_carry = 1'b0;
        end else begin
          sc_result = shr_full[WIDTH:1];
          sc_carry  = shr_full[0];
        end
      end
      OP_IMMED: sc_result = op_b;
      default:  sc_result = {WIDTH{1'b0}};
    endcase
  end

  // Handshake FSM, iterative datapath steps and result/flag updates.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    div_zero_d = div_zero_q;
`ifdef ALU_MULDIV_EN
    step_d     = step_q;
    kind_d     = kind_q;
    acc_d      = acc_q;
    work_d     = work_q;
    opnd_d     = opnd_q;
`endif
    if (accept && is_iter) begin
`ifdef ALU_MULDIV_EN
      state_d = S_CALC;
      step_d  = 5'd0;
      kind_d  = operation;
      acc_d   = {WIDTH{1'b0}};
      work_d  = op_a;
      opnd_d  = op_b;
`endif
    end else if (accept) begin
      state_d    = S_DONE;
      result_d   = sc_result;
      carry_d    = sc_carry;
      zero_d     = (sc_result == {WIDTH{1'b0}});
      div_zero_d = 1'b0;
    end else begin
      case (state_q)
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
`ifdef ALU_MULDIV_EN
        S_CALC: begin
          if (step_q == WIDTH_5) begin
            state_d    = S_DONE;
            result_d   = fin_result;
            zero_d     = (fin_result == {WIDTH{1'b0}});
            div_zero_d = (kind_q != OP_MUL) && (opnd_q == {WIDTH{1'b0}});
          end else if (kind_q == OP_MUL) begin
            step_d = step_q + 5'd1;
            if (work_q[0]) begin
              acc_d = acc_q + opnd_q;
            end else begin
              acc_d = acc_q;
            end
            opnd_d = {opnd_q[WIDTH-2:0], 1'b0};
            work_d = {1'b0, work_q[WIDTH-1:1]};
          end else begin
            step_d = step_q + 5'd1;
            if (rem_shift >= {1'b0, opnd_q}) begin
              acc_d  = rem_sub;
              work_d = {work_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d  = rem_shift[WIDTH-1:0];
              work_d = {work_q[WIDTH-2:0], 1'b0};
            end
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // Control and result registers; rst discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      result_q   <= {WIDTH{1'b0}};
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      div_zero_q <= div_zero_d;
    end
  end

`ifdef ALU_MULDIV_EN
  // Iterative MUL/DIV/MOD working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 5'd0;
      kind_q <= 5'd0;
      acc_q  <= {WIDTH{1'b0}};
      work_q <= {WIDTH{1'b0}};
      opnd_q <= {WIDTH{1'b0}};
    end else begin
      step_q <= step_d;
      kind_q <= kind_d;
      acc_q  <= acc_d;
      work_q <= work_d;
      opnd_q <= opnd_d;
    end
  end
`endif

  assign out_valid  = (state_q == S_DONE);
  assign result     = result_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign div_zero   = div_zero_q;

endmodule
